// File: rtl/module_pulsadores_rd_pkg.sv
// Shared types and constants for the push-button read peripheral.
//   state_t    : per-button debounce FSM state encoding
//   ADDR_LEVEL : register select for the debounced level register
//   ADDR_EVENT : register select for the sticky, clear-on-read press events
package pkg_pulsadores;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic ADDR_LEVEL = 1'b0;
  localparam logic ADDR_EVENT = 1'b1;

endpackage

// File: rtl/module_debounce.sv
// Single-button conditioner: two-flop synchroniser, debounce FSM and
// stability counter.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   btn_i   : raw button pin, asynchronous to clk_i, 1 = pressed
//   level_o : debounced level
//   rise_o  : one-cycle pulse when a press is accepted (releases give no pulse)
// A new level is accepted only after DEBOUNCE_CYCLES consecutive equal
// synchronised samples.
module module_debounce
  import pkg_pulsadores::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  // The sample that enters a WAIT state is the first stable one, so the
  // transition is taken when the counter is about to reach DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync2_q) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!sync2_q) begin
          state_d = S_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync2_q) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/module_pulsadores_rd.sv
// Memory-mapped push-button read peripheral.
//   clk_i  : system clock (10 MHz)
//   rst_i  : asynchronous active-high reset
//   btn_i  : raw button pins, 1 = pressed
//   re_i   : one-cycle read strobe
//   addr_i : 0 = LEVEL (debounced levels), 1 = EVENT (sticky presses, cleared on read)
//   data_o : registered read data, zero-extended, valid one cycle after re_i
//   irq_o  : OR of EVENT, registered, when built with PULSADORES_IRQ_EN;
//            otherwise constant 0
module module_pulsadores_rd
  import pkg_pulsadores::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_i,
  input  logic             re_i,
  input  logic             addr_i,
  output logic [31:0]      data_o,
  output logic             irq_o
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] event_q, event_d;
  logic [31:0]      data_q, data_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    module_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .btn_i  (btn_i[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  always_comb begin
    event_d = event_q;
    data_d  = data_q;
    if (re_i) begin
      data_d = '0;
      if (addr_i == ADDR_LEVEL) begin
        data_d[N_BTN-1:0] = level;
      end else begin
        data_d[N_BTN-1:0] = event_q;
        event_d           = '0;
      end
    end
    // Set is applied after the read clear so a press landing on the read
    // cycle survives for the next read.
    event_d = event_d | rise;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      event_q <= '0;
      data_q  <= '0;
    end else begin
      event_q <= event_d;
      data_q  <= data_d;
    end
  end

  assign data_o = data_q;

`ifdef PULSADORES_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |event_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: doc/module_pulsadores_rd.md
Name: module_pulsadores_rd

Overview:
- Read-side input peripheral: the counterpart of the write-only LED/display peripherals.
- Samples N board push-buttons and synchronises, debounces and edge-detects them.
- Exposes two CPU-readable registers: current debounced level, and sticky "pressed" events that clear on read.
- Sits on the same peripheral bus as the other memory-mapped I/O blocks on the 10 MHz system clock.

Parameters:
- N_BTN, 4, number of buttons (1..16).
- DEBOUNCE_CYCLES, 100000, clock cycles an input must stay stable before it is accepted (10 ms at 10 MHz); minimum 2.

Ports:
- clk_i  input  1  system clock, 10 MHz.
- rst_i  input  1  reset, asynchronous, active-high.
- btn_i  input  N_BTN  raw button pins, asynchronous to clk_i, 1 = pressed.
- re_i  input  1  read enable, one-cycle strobe.
- addr_i  input  1  register select: 0 = LEVEL, 1 = EVENT.
- data_o  output  32  read data, zero-extended from N_BTN.
- irq_o  output  1  interrupt request (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-high. On reset, all of the following are cleared to 0:
  - synchroniser flops, debounce counters and debounced levels;
  - EVENT register;
  - data_o and irq_o.
- Every per-button FSM resets to S_LOW.
- Synchroniser: two flip-flop stages per bit. Raw-to-synchronised latency is 2 cycles.
- Per-button debounce FSM, with states S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW:
  - S_LOW: if sync = 1, go to S_WAIT_HIGH with cnt = 0.
  - S_WAIT_HIGH: if sync = 0, return to S_LOW (cnt cleared). Otherwise cnt++. When cnt = DEBOUNCE_CYCLES-1, go to S_HIGH, set level = 1 and pulse rise for one cycle.
  - S_HIGH and S_WAIT_LOW are symmetric, with level = 0 on acceptance. The release direction produces no event.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter never wraps; it is cleared on every state entry.
- A glitch shorter than DEBOUNCE_CYCLES never changes level.
- Press-to-level latency: 2 + DEBOUNCE_CYCLES cycles after the raw edge.
- EVENT[i] is set by rise[i] and stays set until read.
- Read handshake:
  - On a cycle with re_i = 1, data_o is registered at the next edge, giving 1-cycle latency.
  - addr_i = 0 returns {0, level}.
  - addr_i = 1 returns {0, EVENT}, and all EVENT bits returned are cleared at that same edge.
  - With re_i = 0, data_o holds its last value. LEVEL reads have no side effects.
- Simultaneous rise[i] and EVENT read in the same cycle:
  - data_o shows the old EVENT[i];
  - EVENT[i] ends at 1, because set wins over clear, so no press is lost.
- Reset asserted mid-debounce abandons the pending transition. After release, a held button is re-accepted only after a full DEBOUNCE_CYCLES.

Optional Feature:
- Macro: PULSADORES_IRQ_EN.
- When defined: irq_o is registered as the OR of EVENT. It rises 1 cycle after the first set bit and falls 1 cycle after the read that empties EVENT.
- When undefined: irq_o is tied to 0 and the IRQ register logic is not built.
- Register behaviour is identical in both builds.

Decomposition:
- Package pkg_pulsadores contains:
  - the state typedef (enum logic [1:0] {S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW});
  - register address constants ADDR_LEVEL = 1'b0 and ADDR_EVENT = 1'b1.
- One sub-module, module_debounce: one button, containing the synchroniser, FSM and counter. It outputs level and rise and takes parameter DEBOUNCE_CYCLES.
- The top level instantiates it N_BTN times in a generate loop and holds the EVENT register, read mux and IRQ.

Test Plan (bench uses DEBOUNCE_CYCLES = 8, N_BTN = 4):
- Clean press: btn_i[0] rises and is held 20 cycles. Required: level[0] = 1 exactly 10 cycles after the edge. A LEVEL read then returns 0x00000001 one cycle after re_i.
- Bounce: btn_i[1] toggles high 3 cycles / low 2 cycles, 4 times, then is held high. Required: no level change during the bounce; exactly one EVENT bit set; EVENT read returns 0x00000002.
- Clear-on-read: after a press on btn 2, read EVENT twice. Required: the first read returns 0x00000004, the second returns 0x00000000. irq_o (IRQ_EN build) falls 1 cycle after the first read.
- Set/clear collision: time the EVENT read strobe to coincide with rise[3]. Required: data_o = 0x00000000, EVENT[3] = 1 afterwards, and the next read returns 0x00000008.
- Reset mid-debounce: assert rst_i asynchronously at cnt = 5 while btn_i[0] is held high. Required: data_o, irq_o and level clear immediately. After release, level[0] = 1 only 10 cycles later.
- Release path: release a held button. Required: level returns to 0 after 10 cycles and EVENT does not change.
